// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display path (scan controller and message decoders).
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
//
// Contents: digit codes, "all digits off" / "all segments off" values, segment bit
// positions inside the 7-bit {a,b,c,d,e,f,g} bus, and the one-hot active-low enable helper.
package display_pkg;

   // Digit counter codes, {cnt_msb, cnt_lsb}
   localparam logic [1:0] DIG0 = 2'b00;
   localparam logic [1:0] DIG1 = 2'b01;
   localparam logic [1:0] DIG2 = 2'b10;
   localparam logic [1:0] DIG3 = 2'b11;

   // Active-low digit enables: all digits dark
   localparam logic [3:0] DIGIT_OFF = 4'b1111;

   // Active-high segments: all segments dark
   localparam logic [6:0] SEG_BLANK = 7'b0;

   // Segment bit positions; the bus is ordered {a,b,c,d,e,f,g}, a is the MSB
   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   // Active-low enable for one digit: bit k low selects digit k
   function automatic logic [3:0] digit_enable(input logic [1:0] dig);
      digit_enable = ~(4'b0001 << dig);
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: free-running 0..DIV-1 counter with a wrap pulse and blanking flag.
// Latency: wrap and below_blank are combinational from the count register.
// Backpressure: none; counts every cycle.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset (count returns to 0)
//   wrap          high in the last cycle of a slot (count == DIV-1)
//   below_blank   high while count < BLANK (blanking part of the slot)
module scan_prescaler #(
   parameter int DIV   = 50000,
   parameter int BLANK = 500
) (
   input  logic clk,
   input  logic reset,
   output logic wrap,
   output logic below_blank
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      wrap        = (count_q == CW'(DIV - 1));
      below_blank = (count_q < CW'(BLANK));
      count_d     = count_q + CW'(1);
      if (wrap) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan of a 4-digit 7-segment display with per-slot blanking and VL error hold.
// Latency: digit_en/seg_out lag the digit counter and prescaler by one cycle; vl_hold follows vl_in/clear by one cycle.
// Backpressure: none; free-running scan, seg_in is sampled every cycle.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   seg_in[6:0]        {a..g} from the decoder selected by cnt_msb/cnt_lsb (active-high)
//   vl_in              value-validation error request (level or pulse)
//   clear              any selection active; drops the error hold
//   cnt_msb, cnt_lsb   digit counter to the decoders
//   digit_en[3:0]      active-low digit enables to the pins
//   seg_out[6:0]       registered, blanked segments to the pins
//   frame_done         one-cycle pulse in the first cycle of each frame
//   vl_hold            stretched error, feeds the decoder VL input
module display_scan_controller
   import display_pkg::*;
#(
   parameter int DIV         = 50000,
   parameter int BLANK       = 500,
   parameter int HOLD_FRAMES = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] seg_in,
   input  logic       vl_in,
   input  logic       clear,
   output logic       cnt_msb,
   output logic       cnt_lsb,
   output logic [3:0] digit_en,
   output logic [6:0] seg_out,
   output logic       frame_done,
   output logic       vl_hold
);

   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

   logic              wrap;
   logic              below_blank;

   logic [1:0]        cnt_q,        cnt_d;
   logic [3:0]        digit_en_q,   digit_en_d;
   logic [6:0]        seg_out_q,    seg_out_d;
   logic              frame_done_q, frame_done_d;
   logic              vl_hold_q,    vl_hold_d;
   logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;

   scan_prescaler #(
      .DIV   (DIV),
      .BLANK (BLANK)
   ) u_prescaler (
      .clk         (clk),
      .reset       (reset),
      .wrap        (wrap),
      .below_blank (below_blank)
   );

   // Digit counter and frame marker
   always_comb begin
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      if (wrap) begin
         cnt_d = cnt_q + 2'd1;
         // Registered so the pulse lands in the first cycle of the new frame
         // (cnt=00, prescaler=0) rather than the last cycle of the old one.
         frame_done_d = (cnt_q == DIG3);
      end
   end

   // Output stage: dark for the first BLANK cycles of every slot so the previous
   // digit's segments never show on the newly enabled digit.
   always_comb begin
      digit_en_d = DIGIT_OFF;
      seg_out_d  = SEG_BLANK;
      if (!below_blank) begin
         digit_en_d = digit_enable(cnt_q);
         seg_out_d  = seg_in;
      end
   end

   // Error hold: clear beats vl_in, vl_in (re)loads and beats a same-cycle frame
   // decrement, otherwise each frame_done while held consumes one frame.
   always_comb begin
      vl_hold_d  = vl_hold_q;
      hold_cnt_d = hold_cnt_q;
      if (clear) begin
         vl_hold_d  = 1'b0;
         hold_cnt_d = '0;
      end else if (vl_in) begin
         vl_hold_d  = 1'b1;
         hold_cnt_d = HOLD_W'(HOLD_FRAMES);
      end else if (frame_done_q && vl_hold_q) begin
         hold_cnt_d = hold_cnt_q - HOLD_W'(1);
         if (hold_cnt_q == HOLD_W'(1)) begin
            vl_hold_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= DIG0;
         digit_en_q   <= DIGIT_OFF;
         seg_out_q    <= SEG_BLANK;
         frame_done_q <= 1'b0;
         vl_hold_q    <= 1'b0;
         hold_cnt_q   <= '0;
      end else begin
         cnt_q        <= cnt_d;
         digit_en_q   <= digit_en_d;
         seg_out_q    <= seg_out_d;
         frame_done_q <= frame_done_d;
         vl_hold_q    <= vl_hold_d;
         hold_cnt_q   <= hold_cnt_d;
      end
   end

   assign cnt_msb    = cnt_q[1];
   assign cnt_lsb    = cnt_q[0];
   assign digit_en   = digit_en_q;
   assign seg_out    = seg_out_q;
   assign frame_done = frame_done_q;
   assign vl_hold    = vl_hold_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with a timeline-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_display_scan_controller;

   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int HOLD  = 3;
   localparam int FRAME = 4 * DIV;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] seg_in;
   logic       vl_in;
   logic       clear;
   logic       cnt_msb;
   logic       cnt_lsb;
   logic [3:0] digit_en;
   logic [6:0] seg_out;
   logic       frame_done;
   logic       vl_hold;

   int total = 0;
   int bad   = 0;

   // Model state: cycle index since reset release, last accepted vl_in and clear cycles
   int k         = 0;
   int last_vl   = -1;
   int last_clear = -1;

   always #5 clk = ~clk;

   // Decoder stand-in: pattern derived from the digit counter
   assign seg_in = {cnt_msb, cnt_lsb, cnt_msb, cnt_lsb, cnt_msb, cnt_lsb, 1'b1};

   display_scan_controller #(
      .DIV         (DIV),
      .BLANK       (BLANK),
      .HOLD_FRAMES (HOLD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .seg_in     (seg_in),
      .vl_in      (vl_in),
      .clear      (clear),
      .cnt_msb    (cnt_msb),
      .cnt_lsb    (cnt_lsb),
      .digit_en   (digit_en),
      .seg_out    (seg_out),
      .frame_done (frame_done),
      .vl_hold    (vl_hold)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", tag, k, obs, exp);
      end
   endtask

   // Called at a negedge: check cycle k against the model, drive this cycle's inputs,
   // advance through the posedge and return at the next negedge.
   task automatic step(input logic vl, input logic clr, input logic rst);
      int p, c, exp_en, exp_seg, exp_fd, exp_hold, frames;
      if (k == 0) begin
         exp_en  = 15;
         exp_seg = 0;
      end else begin
         p = (k - 1) % DIV;
         c = ((k - 1) / DIV) % 4;
         if (p < BLANK) begin
            exp_en  = 15;
            exp_seg = 0;
         end else begin
            exp_en  = (~(1 << c)) & 15;
            exp_seg = (c << 5) | (c << 3) | (c << 1) | 1;
         end
      end
      exp_fd = (k > 0 && (k % FRAME) == 0) ? 1 : 0;
      exp_hold = 0;
      if (last_vl >= 0 && last_vl > last_clear) begin
         // frame_done pulses strictly after the last vl_in and before this cycle
         frames = (k - 1) / FRAME - last_vl / FRAME;
         if (frames < HOLD) exp_hold = 1;
      end

      chk("cnt",        32'({cnt_msb, cnt_lsb}), 32'((k / DIV) % 4));
      chk("digit_en",   32'(digit_en),   exp_en);
      chk("seg_out",    32'(seg_out),    exp_seg);
      chk("frame_done", 32'(frame_done), exp_fd);
      chk("vl_hold",    32'(vl_hold),    exp_hold);
      if (digit_en === 4'b1111) chk("dark_seg", 32'(seg_out), 0);

      vl_in = vl;
      clear = clr;
      reset = rst;
      @(posedge clk);
      if (rst) begin
         k          = 0;
         last_vl    = -1;
         last_clear = -1;
      end else begin
         if (clr) last_clear = k;
         else if (vl) last_vl = k;
         k++;
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      vl_in = 1'b0;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      k = 0;

      // Free run with a single vl pulse
      for (int i = 0; i < 100; i++) begin
         if (k == 19) begin
            chk("slot2_seg", 32'(seg_out), 32'h55);
            chk("slot2_en",  32'(digit_en), 32'hB);
         end
         if (k == 32) chk("first_fd",  32'(frame_done), 1);
         if (k == 96) chk("hold_96",   32'(vl_hold), 1);
         if (k == 97) chk("hold_fall", 32'(vl_hold), 0);
         step(k == 5, 1'b0, 1'b0);
      end

      // Re-pulse while held
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 170; i++) begin
         if (k == 160) chk("reload_160", 32'(vl_hold), 1);
         if (k == 161) chk("reload_161", 32'(vl_hold), 0);
         step(k == 5 || k == 70, 1'b0, 1'b0);
      end

      // clear against vl_in
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 60; i++) begin
         if (k == 35) chk("held_35",  32'(vl_hold), 1);
         if (k == 41) chk("clr_wins", 32'(vl_hold), 0);
         if (k == 51) chk("clr_only", 32'(vl_hold), 0);
         step(k == 30 || k == 40, k == 40 || k == 50, 1'b0);
      end

      // Reset mid-slot and mid-hold
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 60; i++) begin
         if (i == 21) begin
            chk("rst_cnt",  32'({cnt_msb, cnt_lsb}), 0);
            chk("rst_en",   32'(digit_en), 32'hF);
            chk("rst_hold", 32'(vl_hold), 0);
         end
         step(i == 10, 1'b0, i == 20);
      end

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 149) == 0,
              $urandom_range(0, 299) == 0,
              $urandom_range(0, 699) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
